// File: rtl/mem_access_unit_if.sv
// Data-memory request/response port of the LC-3b MEM stage.
// The unit drives requests through the master modport; the memory answers through the slave modport.
interface mem_access_unit_if;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp;
  logic [15:0] mem_rdata;

  modport master (
    output mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
    input  mem_resp, mem_rdata
  );

  modport slave (
    input  mem_address, mem_wdata, mem_read, mem_write, mem_byte_enable,
    output mem_resp, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: runs word, byte and indirect (LDI/STI) data-memory accesses and stalls the pipeline.
// Define MEM_INDIRECT_EN to build the pointer-read state; otherwise indirect ops run as direct word accesses.
module mem_access_unit (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               op_valid,
  input  logic               op_read,
  input  logic               op_write,
  input  logic               op_byte,
  input  logic               op_indirect,
  input  logic [15:0]        addr_in,
  input  logic [15:0]        wdata_in,
  input  logic               advance,
  mem_access_unit_if.master  mem,
  output logic [15:0]        rdata_out,
  output logic               stall
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
`ifdef MEM_INDIRECT_EN
    PTR,
`endif
    ACCESS,
    HOLD
  } state_t;

  state_t state;
  logic   is_read;
  logic   is_byte;
  logic   addr_lsb;
  logic   mem_op;
  logic   byte_eff;

  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] a);
    return a & 16'hFFFE;
  endfunction

  function automatic logic [DATA_W-1:0] load_lane(input logic [DATA_W-1:0] d,
                                                  input logic byte_sel, input logic hi);
    if (!byte_sel) return d;
    return hi ? {8'h00, d[15:8]} : {8'h00, d[7:0]};
  endfunction

  function automatic logic [1:0] write_lanes(input logic byte_sel, input logic hi);
    if (!byte_sel) return 2'b11;
    return hi ? 2'b10 : 2'b01;
  endfunction

  assign mem_op   = op_valid && (op_read || op_write);
  // Indirect accesses are always word-sized, with or without the pointer state.
  assign byte_eff = op_byte && !op_indirect;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      is_read             <= 1'b0;
      is_byte             <= 1'b0;
      addr_lsb            <= 1'b0;
      mem.mem_address     <= '0;
      mem.mem_wdata       <= '0;
      mem.mem_read        <= 1'b0;
      mem.mem_write       <= 1'b0;
      mem.mem_byte_enable <= 2'b00;
      rdata_out           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            is_read         <= op_read;
            is_byte         <= byte_eff;
            addr_lsb        <= addr_in[0];
            mem.mem_address <= byte_eff ? addr_in : word_align(addr_in);
            mem.mem_wdata   <= byte_eff ? {wdata_in[7:0], wdata_in[7:0]} : wdata_in;
`ifdef MEM_INDIRECT_EN
            if (op_indirect) begin
              state        <= PTR;
              mem.mem_read <= 1'b1;
            end else begin
`endif
              state               <= ACCESS;
              mem.mem_read        <= op_read;
              mem.mem_write       <= !op_read;
              mem.mem_byte_enable <= op_read ? 2'b00 : write_lanes(byte_eff, addr_in[0]);
`ifdef MEM_INDIRECT_EN
            end
`endif
          end
        end
`ifdef MEM_INDIRECT_EN
        PTR: begin
          // The pointer goes straight into the address register, so it is used the next cycle.
          if (mem.mem_resp) begin
            state               <= ACCESS;
            mem.mem_address     <= word_align(mem.mem_rdata);
            mem.mem_read        <= is_read;
            mem.mem_write       <= !is_read;
            mem.mem_byte_enable <= is_read ? 2'b00 : 2'b11;
          end
        end
`endif
        ACCESS: begin
          if (mem.mem_resp) begin
            state               <= HOLD;
            mem.mem_read        <= 1'b0;
            mem.mem_write       <= 1'b0;
            mem.mem_byte_enable <= 2'b00;
            if (is_read) rdata_out <= load_lane(mem.mem_rdata, is_byte, addr_lsb);
          end
        end
        HOLD: begin
          if (advance) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = mem_op;
`ifdef MEM_INDIRECT_EN
      PTR:     stall = 1'b1;
`endif
      ACCESS:  stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a transaction-level model predicts every request,
// stall and load result cycle by cycle; directed cases pin the model to literal values.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        op_valid, op_read, op_write, op_byte, op_indirect, advance;
  logic [15:0] addr_in, wdata_in;
  logic [15:0] rdata_out;
  logic        stall;

  mem_access_unit_if mem_if ();

  mem_access_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op_valid   (op_valid),
    .op_read    (op_read),
    .op_write   (op_write),
    .op_byte    (op_byte),
    .op_indirect(op_indirect),
    .addr_in    (addr_in),
    .wdata_in   (wdata_in),
    .advance    (advance),
    .mem        (mem_if),
    .rdata_out  (rdata_out),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_rd, exp_wr;
  logic [1:0]  exp_be;
  logic [15:0] exp_addr, exp_wdata, exp_rdata;

  logic [15:0] mem_tbl [logic [15:0]];

  // Observations from the most recent operation
  logic [15:0] seen_addr [2];
  logic [15:0] seen_wdata;
  logic [1:0]  seen_be;
  logic        seen_wr;
  int          n_stall;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [15:0] memread(input logic [15:0] a);
    if (mem_tbl.exists(a)) return mem_tbl[a];
    return (a * 16'h3D1B) ^ 16'hA5C3;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", {15'd0, stall}, {15'd0, exp_stall});
      check("mem_read", {15'd0, mem_if.mem_read}, {15'd0, exp_rd});
      check("mem_write", {15'd0, mem_if.mem_write}, {15'd0, exp_wr});
      check("mem_byte_enable", {14'd0, mem_if.mem_byte_enable}, {14'd0, exp_be});
      check("rdata_out", rdata_out, exp_rdata);
      if (exp_rd || exp_wr) check("mem_address", mem_if.mem_address, exp_addr);
      if (exp_wr) check("mem_wdata", mem_if.mem_wdata, exp_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic garbage_inputs();
    op_valid    = 1'($urandom);
    op_read     = 1'($urandom);
    op_write    = !op_read;
    op_byte     = 1'($urandom);
    op_indirect = 1'($urandom);
    addr_in     = 16'($urandom);
    wdata_in    = 16'($urandom);
  endtask

  task automatic idle_outputs();
    exp_stall = 1'b0;
    exp_rd    = 1'b0;
    exp_wr    = 1'b0;
    exp_be    = 2'b00;
  endtask

  // One instruction in the EX/MEM latch; lat_force=0 picks random latencies.
  task automatic do_op(input logic v, input logic rd, input logic wr, input logic byt,
                       input logic ind, input logic [15:0] a, input logic [15:0] w,
                       input int lat_force, input int hold_n);
    logic        memop, eb, indirect;
    int          ntx, lat;
    logic [15:0] tx_addr [2];
    logic [15:0] ptr, wd, final_rdata, d;
    logic [1:0]  be;

    memop = v && (rd || wr);
    eb    = byt && !ind;
`ifdef MEM_INDIRECT_EN
    indirect = ind;
`else
    indirect = 1'b0;
`endif
    wd = eb ? {w[7:0], w[7:0]} : w;
    be = eb ? (a[0] ? 2'b10 : 2'b01) : 2'b11;
    if (indirect) begin
      ntx        = 2;
      tx_addr[0] = {a[15:1], 1'b0};
      ptr        = memread(tx_addr[0]);
      tx_addr[1] = {ptr[15:1], 1'b0};
    end else begin
      ntx        = 1;
      tx_addr[0] = eb ? a : {a[15:1], 1'b0};
      tx_addr[1] = 16'h0;
    end
    d = memread(tx_addr[ntx-1]);
    if (!eb)      final_rdata = d;
    else if (a[0]) final_rdata = {8'h00, d[15:8]};
    else          final_rdata = {8'h00, d[7:0]};

    op_valid = v; op_read = rd; op_write = wr; op_byte = byt; op_indirect = ind;
    addr_in = a; wdata_in = w; advance = 1'b0;
    mem_if.mem_resp  = 1'($urandom);
    mem_if.mem_rdata = 16'($urandom);
    idle_outputs();
    exp_stall = memop;
    n_stall = 0;
    @(negedge clk);
    if (stall) n_stall++;
    tick();

    if (memop) begin
      for (int t = 0; t < ntx; t++) begin
        lat = (lat_force > 0) ? lat_force : int'($urandom_range(1, 4));
        for (int k = 1; k <= lat; k++) begin
          garbage_inputs();
          advance   = 1'($urandom);
          exp_stall = 1'b1;
          exp_rd    = (t < ntx - 1) ? 1'b1 : rd;
          exp_wr    = (t < ntx - 1) ? 1'b0 : !rd;
          exp_addr  = tx_addr[t];
          exp_wdata = wd;
          exp_be    = exp_wr ? (indirect ? 2'b11 : be) : 2'b00;
          mem_if.mem_resp  = (k == lat);
          mem_if.mem_rdata = (k == lat) ? memread(tx_addr[t]) : 16'($urandom);
          @(negedge clk);
          if (stall) n_stall++;
          if (k == 1) begin
            seen_addr[t] = mem_if.mem_address;
            seen_wdata   = mem_if.mem_wdata;
            seen_be      = mem_if.mem_byte_enable;
            seen_wr      = mem_if.mem_write;
          end
          tick();
          if (k == lat && t == ntx - 1 && rd) exp_rdata = final_rdata;
        end
      end
      for (int h = 0; h <= hold_n; h++) begin
        garbage_inputs();
        advance = (h == hold_n);
        mem_if.mem_resp  = 1'($urandom);
        mem_if.mem_rdata = 16'($urandom);
        idle_outputs();
        @(negedge clk);
        if (stall) n_stall++;
        tick();
      end
    end
    op_valid = 1'b0; op_read = 1'b0; op_write = 1'b0; op_byte = 1'b0; op_indirect = 1'b0;
    advance = 1'b0;
    mem_if.mem_resp = 1'b0;
    idle_outputs();
  endtask

  initial begin
    reset_n = 1'b0;
    op_valid = 1'b0; op_read = 1'b0; op_write = 1'b0; op_byte = 1'b0; op_indirect = 1'b0;
    addr_in = 16'h0; wdata_in = 16'h0; advance = 1'b0;
    mem_if.mem_resp = 1'b0; mem_if.mem_rdata = 16'h0;
    idle_outputs();
    exp_addr = 16'h0; exp_wdata = 16'h0; exp_rdata = 16'h0;

    mem_tbl[16'h1234] = 16'hBEEF;
    mem_tbl[16'h2001] = 16'hA55A;
    mem_tbl[16'h4000] = 16'h5002;
    mem_tbl[16'h5002] = 16'h1111;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset mem_read", {15'd0, mem_if.mem_read}, 16'h0);
    check("reset mem_write", {15'd0, mem_if.mem_write}, 16'h0);
    check("reset byte_enable", {14'd0, mem_if.mem_byte_enable}, 16'h0);
    check("reset stall", {15'd0, stall}, 16'h0);
    check("reset rdata_out", rdata_out, 16'h0);
    check("reset mem_address", mem_if.mem_address, 16'h0);
    check("reset mem_wdata", mem_if.mem_wdata, 16'h0);
    tick();
    reset_n = 1'b1;
    chk_en  = 1'b1;
    tick();

    // LDR, latency 2
    do_op(1, 1, 0, 0, 0, 16'h1235, 16'h0, 2, 0);
    check("ldr address", seen_addr[0], 16'h1234);
    check("ldr stall cycles", 16'(n_stall), 16'd3);
    @(negedge clk);
    check("ldr rdata", rdata_out, 16'hBEEF);
    tick();

    // LDB odd address
    do_op(1, 1, 0, 1, 0, 16'h2001, 16'h0, 1, 0);
    check("ldb address", seen_addr[0], 16'h2001);
    check("ldb stall cycles", 16'(n_stall), 16'd2);
    @(negedge clk);
    check("ldb rdata", rdata_out, 16'h00A5);
    tick();

    // STB odd address, result register untouched by the store
    do_op(1, 0, 1, 1, 0, 16'h3003, 16'h00C7, 3, 1);
    check("stb wdata", seen_wdata, 16'hC7C7);
    check("stb byte_enable", {14'd0, seen_be}, 16'h0002);
    check("stb write", {15'd0, seen_wr}, 16'h0001);
    check("stb address", seen_addr[0], 16'h3003);
    @(negedge clk);
    check("stb rdata held", rdata_out, 16'h00A5);
    tick();

    // LDI with a 4-cycle hold in HOLD
    do_op(1, 1, 0, 0, 1, 16'h4000, 16'h0, 1, 4);
    check("ldi first address", seen_addr[0], 16'h4000);
    @(negedge clk);
`ifdef MEM_INDIRECT_EN
    check("ldi second address", seen_addr[1], 16'h5002);
    check("ldi rdata", rdata_out, 16'h1111);
    check("ldi stall cycles", 16'(n_stall), 16'd3);
`else
    check("ldi direct rdata", rdata_out, 16'h5002);
    check("ldi stall cycles", 16'(n_stall), 16'd2);
`endif
    tick();

    // Reset during ACCESS, then a late response
    chk_en = 1'b0;
    op_valid = 1'b1; op_read = 1'b1; op_write = 1'b0; op_byte = 1'b0; op_indirect = 1'b0;
    addr_in = 16'h6000;
    mem_if.mem_resp = 1'b0;
    tick();
    op_valid = 1'b0;
    @(negedge clk);
    check("access mem_read", {15'd0, mem_if.mem_read}, 16'h0001);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset drops mem_read", {15'd0, mem_if.mem_read}, 16'h0);
    check("reset drops stall", {15'd0, stall}, 16'h0);
    tick();
    reset_n = 1'b1;
    mem_if.mem_resp  = 1'b1;
    mem_if.mem_rdata = 16'h7777;
    @(negedge clk);
    check("late resp mem_read", {15'd0, mem_if.mem_read}, 16'h0);
    tick();
    mem_if.mem_resp = 1'b0;
    @(negedge clk);
    check("late resp stall", {15'd0, stall}, 16'h0);
    check("late resp rdata", rdata_out, 16'h0);
    check("late resp mem_read after", {15'd0, mem_if.mem_read}, 16'h0);
    exp_rdata = 16'h0;
    idle_outputs();
    tick();
    chk_en = 1'b1;

    // Random mix
    for (int i = 0; i < 300; i++) begin
      logic v, rd, wr;
      int kind;
      v    = ($urandom_range(0, 9) != 0);
      kind = int'($urandom_range(0, 4));
      rd   = (kind <= 1);
      wr   = (kind == 2 || kind == 3);
      do_op(v, rd, wr, 1'($urandom), 1'($urandom_range(0, 3) == 0),
            16'($urandom), 16'($urandom), 0, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage consumer of the EX/MEM pipeline latch in the pipelined LC-3b datapath. Takes the decoded memory operation (address, store data, control flags) presented by the latch and performs the data-memory transaction over the request/response port. Supports word, byte, and indirect (LDI/STI) accesses. Holds the pipeline stalled until the result is ready for the MEM/WB latch.

## Interface
Parameters:
- None; widths fixed by lc3b_word (16 bits).

Ports:
- Clock and reset: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- op_valid  input  1  EX/MEM latch holds a memory instruction (not a squashed bubble).
- op_read  input  1  load operation (LDR/LDB/LDI).
- op_write  input  1  store operation (STR/STB/STI); never asserted together with op_read.
- op_byte  input  1  byte access (LDB/STB).
- op_indirect  input  1  indirect access (LDI/STI).
- addr_in  input  16  effective address from the latch ALU field.
- wdata_in  input  16  store data from the latch sr2 field.
- advance  input  1  the pipeline latches load this cycle.
- mem_address  output  16  data-memory address.
- mem_wdata  output  16  data-memory write data.
- mem_read  output  1  read request.
- mem_write  output  1  write request.
- mem_byte_enable  output  2  byte lanes for writes.
- mem_resp  input  1  one-cycle transaction-complete pulse.
- mem_rdata  input  16  read data; valid when mem_resp=1.
- rdata_out  output  16  load result to MEM/WB.
- stall  output  1  holds all upstream latches.

## Operation
- States: IDLE, PTR (indirect pointer read), ACCESS (final access), HOLD (result ready).
- IDLE: when op_valid and (op_read or op_write), capture addr/wdata/flags. Go to PTR if op_indirect, otherwise ACCESS.
- PTR: mem_read=1, mem_address={addr[15:1],1'b0}. On mem_resp, capture the pointer from mem_rdata and go to ACCESS.
- ACCESS:
  - Address is the pointer for indirect operations, otherwise the captured address.
  - Word accesses force bit 0 of the address to 0.
  - mem_read or mem_write per the operation.
  - On mem_resp, go to HOLD.
- HOLD: stall=0. Go to IDLE on advance=1; otherwise stay.
- Write data and byte lanes:
  - Word write: mem_wdata=wdata, mem_byte_enable=2'b11.
  - Byte write: mem_wdata={wdata[7:0],wdata[7:0]}; mem_byte_enable=2'b10 if addr[0]=1, else 2'b01.
  - Indirect operations are always word.
  - mem_byte_enable=2'b00 when no write is asserted.
- Load result:
  - Word load: rdata_out=mem_rdata.
  - Byte load: rdata_out is the zero-extended mem_rdata[15:8] if addr[0]=1, else mem_rdata[7:0].
  - rdata_out is registered on the final mem_resp and held until the next load completes.
- stall = 1 when (state==IDLE and a memory op is presented) or state is PTR or ACCESS; 0 otherwise.
- Non-memory or squashed instructions (op_valid=0) pass through with stall=0 and no memory request.

## Timing
- Reset: state=IDLE; mem_read, mem_write, mem_byte_enable, stall, rdata_out, mem_address, mem_wdata all 0. Reset mid-transaction drops requests immediately; the in-flight mem_resp is ignored.
- mem_read, mem_write, mem_address, mem_wdata, and mem_byte_enable are decoded from registered state and captured operands only; none depend combinationally on mem_resp.
- Direct operation with response latency L (cycles after the first request cycle): request cycles 1..L; HOLD at cycle L+1; minimum total 3 cycles with L=1.
- Indirect operation: two back-to-back transactions; the pointer is used the cycle after its mem_resp.
- mem_resp outside PTR or ACCESS is ignored.
- Inputs are sampled only in IDLE; changes during PTR, ACCESS, or HOLD have no effect.

## Configuration
- MEM_INDIRECT_EN defined: PTR state and pointer register are present; LDI/STI are supported as above.
- MEM_INDIRECT_EN undefined: PTR state and pointer register are absent; op_indirect is ignored and the operation is treated as a direct word access.

## Test plan
- LDR: addr_in=0x1235, op_read, mem_rdata=0xBEEF with L=2 -> mem_address=0x1234; stall=1 for 3 cycles; rdata_out=0xBEEF in HOLD.
- LDB odd: addr_in=0x2001, mem_rdata=0xA55A -> rdata_out=0x00A5; mem_address=0x2001.
- STB odd: addr_in=0x3003, wdata_in=0x00C7 -> mem_wdata=0xC7C7, mem_byte_enable=2'b10, mem_write=1 until mem_resp.
- LDI (MEM_INDIRECT_EN): addr 0x4000 returns 0x5002; 0x5002 returns 0x1111 -> two reads in order; rdata_out=0x1111. Without the macro: a single read at 0x4000.
- HOLD with advance=0 for 4 cycles -> stall=0, no new request, rdata_out stable; advance=1 -> IDLE.
- reset_n low during ACCESS -> mem_read=0 immediately; a late mem_resp after release causes no state change.
